carfield_boot_seq: RTL and testbench

Hardware multi-domain boot sequencer for the Carfield SoC. It brings up `NumDomains` subsystems in ascending index order: security island, safety island, Cheshire, and any accelerator domains. For each enabled domain it releases reset, programs the boot address, asserts fetch-enable and optionally waits for end-of-computation (EOC) with a timeout. It sits beside the SoC control registers and replaces sequencing that is currently done from simulation or an external debugger. It collects a single aggregate exit code for software and test harnesses.

---
 rtl/carfield_boot_pkg.sv | 29 ++
 rtl/carfield_boot_timer.sv | 29 ++
 rtl/carfield_boot_seq.sv | 204 ++++++++++++++++++++
 tb/tb_carfield_boot_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/carfield_boot_pkg.sv
// carfield_boot_pkg
// Shared definitions for the Carfield multi-domain boot sequencer:
//   - boot_state_e        : sequencer FSM states
//   - EocTimeoutCode      : aggregate exit code reported when a domain times out
//   - Scratch* positions  : layout of the per-domain EOC scratch register
//   - scratch_exit_code() : extracts the exit code carried by a scratch word
package carfield_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RELEASE,
    FETCH,
    WAIT_EOC,
    NEXT,
    DONE
  } boot_state_e;

  localparam logic [31:0] EocTimeoutCode = 32'hFFFF_FFFF;

  // Scratch word: bit 0 flags end-of-computation, the remaining bits hold the exit code.
  localparam int ScratchEocBit  = 0;
  localparam int ScratchCodeLsb = 1;
  localparam int ScratchCodeMsb = 31;

  function automatic logic [31:0] scratch_exit_code(input logic [31:0] scratch);
    return {1'b0, scratch[ScratchCodeMsb:ScratchCodeLsb]};
  endfunction

endpackage

// File: rtl/carfield_boot_timer.sv
// carfield_boot_timer
// Loadable saturating up-counter. The sequencer reuses one instance for both the
// reset-release delay and the EOC timeout.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   load        : load load_value this cycle instead of counting
//   load_value  : value to load
//   count       : current count; sticks at all-ones instead of wrapping
module carfield_boot_timer #(
  parameter int Width = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  output logic [Width-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '1) begin
      count <= count + Width'(1);
    end
  end

endmodule

// File: rtl/carfield_boot_seq.sv
// carfield_boot_seq
// Multi-domain boot sequencer. Enabled domains are brought up in ascending index
// order: release reset, present the boot address, wait RstDelay cycles, raise
// fetch-enable, then optionally wait for the domain's EOC (with timeout). The
// first non-zero exit code or timeout is kept as the aggregate result.
// Ports:
//   clk_i, rst_ni      : clock and asynchronous active-low reset
//   start_i            : one-cycle start pulse, honoured only when idle
//   dom_en_i           : domains taking part in the sequence (sampled at start)
//   dom_wait_i         : domains whose EOC is awaited (sampled at start)
//   boot_addr_i        : per-domain entry points (sampled at start)
//   timeout_i          : EOC timeout in cycles, 0 disables (sampled at start)
//   scratch_i          : per-domain EOC/exit-code registers
//   dom_rst_no         : per-domain reset, active low
//   dom_fetch_en_o     : per-domain fetch-enable level
//   dom_boot_addr_o    : per-domain registered boot address
//   busy_o, done_o     : sequence in progress / one-cycle completion pulse
//   exit_code_o        : aggregate result, held until the next start
//   fail_dom_o         : first failing domain
//   timeout_o          : the recorded failure was a timeout
module carfield_boot_seq #(
  parameter int NumDomains   = 3,
  parameter int AddrWidth    = 64,
  parameter int TimeoutWidth = 24,
  parameter int RstDelay     = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 start_i,
  input  logic [NumDomains-1:0]                dom_en_i,
  input  logic [NumDomains-1:0]                dom_wait_i,
  input  logic [NumDomains-1:0][AddrWidth-1:0] boot_addr_i,
  input  logic [TimeoutWidth-1:0]              timeout_i,
  input  logic [NumDomains-1:0][31:0]          scratch_i,
  output logic [NumDomains-1:0]                dom_rst_no,
  output logic [NumDomains-1:0]                dom_fetch_en_o,
  output logic [NumDomains-1:0][AddrWidth-1:0] dom_boot_addr_o,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic [31:0]                          exit_code_o,
  output logic [$clog2(NumDomains)-1:0]        fail_dom_o,
  output logic                                 timeout_o
);

  import carfield_boot_pkg::*;

  localparam int IdxW = $clog2(NumDomains);
  // Last RELEASE count value: RELEASE lasts exactly RstDelay cycles.
  localparam logic [TimeoutWidth-1:0] RelLast = TimeoutWidth'(RstDelay - 1);

  boot_state_e                          state;
  logic [IdxW-1:0]                      cur;
  logic [NumDomains-1:0]                en_q;
  logic [NumDomains-1:0]                wait_q;
  logic [NumDomains-1:0][AddrWidth-1:0] addr_q;
  logic [TimeoutWidth-1:0]              timeout_q;

  logic                    timer_load;
  logic [TimeoutWidth-1:0] count;

  logic            first_found;
  logic [IdxW-1:0] first_idx;
  logic            next_found;
  logic [IdxW-1:0] next_idx;

  logic [31:0] eoc_code;
  logic        eoc_seen;
  logic        timed_out;

  // The timer runs only while waiting in RELEASE or WAIT_EOC; every other state
  // holds it at zero so both waits start counting from 0 on entry.
  assign timer_load = (state != RELEASE) && (state != WAIT_EOC);

  carfield_boot_timer #(
    .Width(TimeoutWidth)
  ) u_timer (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .load      (timer_load),
    .load_value('0),
    .count     (count)
  );

  // Lowest-set-bit search: the first enabled domain for a fresh start, and the
  // next enabled domain strictly above the current one. Iterating downwards
  // lets the lowest matching index win.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = NumDomains - 1; i >= 0; i--) begin
      if (dom_en_i[i]) begin
        first_found = 1'b1;
        first_idx   = IdxW'(i);
      end
      if (en_q[i] && (i > int'(cur))) begin
        next_found = 1'b1;
        next_idx   = IdxW'(i);
      end
    end
  end

  assign eoc_code  = scratch_exit_code(scratch_i[cur]);
  assign eoc_seen  = scratch_i[cur][ScratchEocBit];
  assign timed_out = (timeout_q != '0) && (count >= timeout_q);

  // Sequencer FSM. Outputs are registered and change on state entry, so a
  // domain's reset release is visible in its first RELEASE cycle and its
  // fetch-enable in its FETCH cycle. Released domains are never put back into
  // reset here; only rst_ni does that.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= IDLE;
      cur             <= '0;
      en_q            <= '0;
      wait_q          <= '0;
      addr_q          <= '0;
      timeout_q       <= '0;
      dom_rst_no      <= '0;
      dom_fetch_en_o  <= '0;
      dom_boot_addr_o <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      exit_code_o     <= '0;
      fail_dom_o      <= '0;
      timeout_o       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            en_q        <= dom_en_i;
            wait_q      <= dom_wait_i;
            addr_q      <= boot_addr_i;
            timeout_q   <= timeout_i;
            exit_code_o <= '0;
            fail_dom_o  <= '0;
            timeout_o   <= 1'b0;
            if (first_found) begin
              cur                        <= first_idx;
              dom_rst_no[first_idx]      <= 1'b1;
              dom_boot_addr_o[first_idx] <= boot_addr_i[first_idx];
              busy_o                     <= 1'b1;
              state                      <= RELEASE;
            end else begin
              done_o <= 1'b1;
              state  <= DONE;
            end
          end
        end

        RELEASE: begin
          if (count == RelLast) begin
            dom_fetch_en_o[cur] <= 1'b1;
            state               <= FETCH;
          end
        end

        FETCH: begin
          state <= wait_q[cur] ? WAIT_EOC : NEXT;
        end

        // EOC is checked before the timeout so a coincident pair resolves as EOC.
        WAIT_EOC: begin
          if (eoc_seen) begin
            if ((exit_code_o == '0) && (eoc_code != '0)) begin
              exit_code_o <= eoc_code;
              fail_dom_o  <= cur;
            end
            state <= NEXT;
          end else if (timed_out) begin
            if (exit_code_o == '0) begin
              exit_code_o <= EocTimeoutCode;
              timeout_o   <= 1'b1;
              fail_dom_o  <= cur;
            end
            state <= NEXT;
          end
        end

        NEXT: begin
          if (next_found) begin
            cur                       <= next_idx;
            dom_rst_no[next_idx]      <= 1'b1;
            dom_boot_addr_o[next_idx] <= addr_q[next_idx];
            state                     <= RELEASE;
          end else begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= DONE;
          end
        end

        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_carfield_boot_seq.sv
// tb_carfield_boot_seq
// Directed bench for carfield_boot_seq. Each started sequence pushes its expected
// aggregate result and start-to-done latency into a queue; a monitor pops and
// compares whenever done_o pulses. Reset/fetch-enable rise cycles are recorded
// relative to the start pulse and compared after each sequence.
module tb_carfield_boot_seq;

  localparam int NumDomains   = 3;
  localparam int AddrWidth    = 64;
  localparam int TimeoutWidth = 24;
  localparam int RstDelay     = 16;

  logic                                 clk = 1'b0;
  logic                                 rst_n = 1'b0;
  logic                                 start = 1'b0;
  logic [NumDomains-1:0]                dom_en = '0;
  logic [NumDomains-1:0]                dom_wait = '0;
  logic [NumDomains-1:0][AddrWidth-1:0] boot_addr;
  logic [TimeoutWidth-1:0]              timeout = '0;
  logic [NumDomains-1:0][31:0]          scratch = '0;
  logic [NumDomains-1:0]                dom_rst_n;
  logic [NumDomains-1:0]                dom_fetch_en;
  logic [NumDomains-1:0][AddrWidth-1:0] dom_boot_addr;
  logic                                 busy;
  logic                                 done;
  logic [31:0]                          exit_code;
  logic [1:0]                           fail_dom;
  logic                                 timeout_flag;

  typedef struct {
    string       name;
    logic [31:0] exit_code;
    logic [1:0]  fail_dom;
    logic        timeout;
    int          latency;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   last_latency = -1;
  int   rst_rise[NumDomains];
  int   fetch_rise[NumDomains];
  logic [NumDomains-1:0] prev_rst = '0;
  logic [NumDomains-1:0] prev_fetch = '0;

  carfield_boot_seq #(
    .NumDomains  (NumDomains),
    .AddrWidth   (AddrWidth),
    .TimeoutWidth(TimeoutWidth),
    .RstDelay    (RstDelay)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .dom_en_i       (dom_en),
    .dom_wait_i     (dom_wait),
    .boot_addr_i    (boot_addr),
    .timeout_i      (timeout),
    .scratch_i      (scratch),
    .dom_rst_no     (dom_rst_n),
    .dom_fetch_en_o (dom_fetch_en),
    .dom_boot_addr_o(dom_boot_addr),
    .busy_o         (busy),
    .done_o         (done),
    .exit_code_o    (exit_code),
    .fail_dom_o     (fail_dom),
    .timeout_o      (timeout_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      last_latency = cyc - start_cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done_o=1 expected no completion");
      end else begin
        e = exp_q.pop_front();
        check_output({e.name, ".exit_code"}, exit_code, e.exit_code);
        check_output({e.name, ".fail_dom"}, fail_dom, e.fail_dom);
        check_output({e.name, ".timeout"}, timeout_flag, e.timeout);
        check_output({e.name, ".busy_at_done"}, busy, 1'b0);
        if (e.latency >= 0) check_output({e.name, ".latency"}, last_latency, e.latency);
      end
    end
  end

  // Records the cycle (relative to the start pulse) at which each domain leaves
  // reset and raises fetch-enable.
  always @(negedge clk) begin
    for (int d = 0; d < NumDomains; d++) begin
      if (dom_rst_n[d] && !prev_rst[d]) rst_rise[d] = cyc - start_cyc;
      if (dom_fetch_en[d] && !prev_fetch[d]) fetch_rise[d] = cyc - start_cyc;
    end
    prev_rst   = dom_rst_n;
    prev_fetch = dom_fetch_en;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives the configuration with a start pulse (cycle 0) and, when push is
  // set, queues the expected completion. Returns at the negedge of cycle 1.
  task automatic apply_stimulus(input string name, input logic [2:0] en, input logic [2:0] wt,
                                input logic [23:0] tmo, input logic [2:0][31:0] scr,
                                input logic [31:0] x_code, input logic [1:0] x_dom,
                                input logic x_tmo, input int x_lat, input bit push);
    exp_t e;
    @(negedge clk);
    dom_en   = en;
    dom_wait = wt;
    timeout  = tmo;
    scratch  = scr;
    for (int d = 0; d < NumDomains; d++) begin
      rst_rise[d]   = -1;
      fetch_rise[d] = -1;
    end
    if (push) begin
      e.name      = name;
      e.exit_code = x_code;
      e.fail_dom  = x_dom;
      e.timeout   = x_tmo;
      e.latency   = x_lat;
      exp_q.push_back(e);
    end
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s.done_wait: got no done_o within %0d cycles expected done_o", name, limit);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    for (int d = 0; d < NumDomains; d++) begin
      boot_addr[d]  = 64'h0000_0000_8000_0000 + 64'(d) * 64'h1000;
      rst_rise[d]   = -1;
      fetch_rise[d] = -1;
    end

    // Reset values
    repeat (2) @(negedge clk);
    check_output("reset.dom_rst_no", dom_rst_n, 3'b000);
    check_output("reset.fetch_en", dom_fetch_en, 3'b000);
    check_output("reset.boot_addr0", dom_boot_addr[0], 64'h0);
    check_output("reset.busy_done", {busy, done}, 2'b00);
    check_output("reset.exit_code", exit_code, 32'h0);
    check_output("reset.fail_timeout", {fail_dom, timeout_flag}, 3'b000);
    rst_n = 1'b1;

    // All domains wait, all report EOC with exit code 0; a second start is ignored.
    apply_stimulus("all_ok", 3'b111, 3'b111, 24'd0, {32'h1, 32'h1, 32'h1},
                   32'h0, 2'd0, 1'b0, 58, 1'b1);
    check_output("all_ok.busy_cycle1", busy, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("all_ok", 200);
    check_output("all_ok.rst_rise0", rst_rise[0], 1);
    check_output("all_ok.rst_rise1", rst_rise[1], 20);
    check_output("all_ok.rst_rise2", rst_rise[2], 39);
    check_output("all_ok.fetch_rise0", fetch_rise[0], 17);
    check_output("all_ok.fetch_rise2", fetch_rise[2], 55);
    check_output("all_ok.boot_addr1", dom_boot_addr[1], 64'h0000_0000_8000_1000);
    check_output("all_ok.boot_addr2", dom_boot_addr[2], 64'h0000_0000_8000_2000);
    check_output("all_ok.final_rst_fetch", {dom_rst_n, dom_fetch_en}, 6'b111_111);

    // First non-zero exit code wins: domain 1 reports 7 -> code 3, domain 2's code 2 ignored.
    do_reset();
    apply_stimulus("exit_code", 3'b111, 3'b111, 24'd0, {32'h5, 32'h7, 32'h1},
                   32'h3, 2'd1, 1'b0, 58, 1'b1);
    wait_done("exit_code", 200);

    // No domain enabled: straight to DONE, previous result cleared, released domains stay out of reset.
    apply_stimulus("none_en", 3'b000, 3'b000, 24'd0, {32'h1, 32'h1, 32'h1},
                   32'h0, 2'd0, 1'b0, 1, 1'b1);
    wait_done("none_en", 20);
    check_output("none_en.rst_kept", dom_rst_n, 3'b111);

    // Domain 1 disabled: stays in reset, domain 2 follows domain 0 directly.
    do_reset();
    apply_stimulus("skip_d1", 3'b101, 3'b101, 24'd0, {32'h1, 32'h1, 32'h1},
                   32'h0, 2'd0, 1'b0, 39, 1'b1);
    wait_done("skip_d1", 200);
    check_output("skip_d1.rst_rise2", rst_rise[2], 20);
    check_output("skip_d1.fetch_rise2", fetch_rise[2], 36);
    check_output("skip_d1.rst_rise1", rst_rise[1], -1);
    check_output("skip_d1.final_rst_fetch", {dom_rst_n, dom_fetch_en}, 6'b101_101);
    check_output("skip_d1.boot_addr1", dom_boot_addr[1], 64'h0);

    // No waiting: fetch-enables at 17, 35, 53 and done at 55.
    do_reset();
    apply_stimulus("no_wait", 3'b111, 3'b000, 24'd0, {32'h0, 32'h0, 32'h0},
                   32'h0, 2'd0, 1'b0, 55, 1'b1);
    wait_done("no_wait", 200);
    check_output("no_wait.fetch_rise0", fetch_rise[0], 17);
    check_output("no_wait.fetch_rise1", fetch_rise[1], 35);
    check_output("no_wait.fetch_rise2", fetch_rise[2], 53);

    // Domain 0 silent with timeout 100: timeout recorded, domain 1 still boots and its code is ignored.
    do_reset();
    apply_stimulus("timeout", 3'b011, 3'b011, 24'd100, {32'h1, 32'h7, 32'h0},
                   32'hFFFF_FFFF, 2'd0, 1'b1, -1, 1'b1);
    wait_done("timeout", 400);
    check_output("timeout.min_latency", last_latency >= 138, 1'b1);
    check_output("timeout.final_rst_fetch", {dom_rst_n, dom_fetch_en}, 6'b011_011);

    // Reset asserted while domain 1 waits for an EOC that never comes.
    do_reset();
    apply_stimulus("rst_mid", 3'b111, 3'b111, 24'd0, {32'h1, 32'h0, 32'h1},
                   32'h0, 2'd0, 1'b0, -1, 1'b0);
    n = 0;
    while (!dom_fetch_en[1] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output("rst_mid.reached_d1", dom_fetch_en[1], 1'b1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_mid.rst_all", dom_rst_n, 3'b000);
    check_output("rst_mid.busy_fetch", {busy, dom_fetch_en}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus("restart", 3'b111, 3'b111, 24'd0, {32'h1, 32'h1, 32'h1},
                   32'h0, 2'd0, 1'b0, 58, 1'b1);
    wait_done("restart", 200);
    check_output("restart.rst_rise0", rst_rise[0], 1);
    check_output("restart.fetch_rise1", fetch_rise[1], 36);

    repeat (3) @(negedge clk);
    check_output("scoreboard.empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
